// File: rtl/cpu_pkg.sv
// Shared constants for the control unit / datapath pair: control-word bit
// positions, opcodes, flag positions and the default datapath width.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;

    localparam int CS_MBR2BR    = 6;
    localparam int CS_ACC2ALU   = 7;
    localparam int CS_MBR2ACC   = 10;
    localparam int CS_BR2ALU    = 14;
    localparam int CS_ACC_CLEAR = 21;
    localparam int CS_ADD       = 22;
    localparam int CS_SUB       = 23;
    localparam int CS_AND       = 24;
    localparam int CS_OR        = 25;
    localparam int CS_NOT       = 26;
    localparam int CS_LSL       = 27;
    localparam int CS_LSR       = 28;
    localparam int CS_MPY       = 29;
    localparam int CS_ASL       = 30;
    localparam int CS_ASR       = 31;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_STORE  = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHIFTR = 8'h0D;
    localparam logic [7:0] OP_SHIFTL = 8'h0E;

    localparam int FLG_Z    = 0;
    localparam int FLG_N    = 1;
    localparam int FLG_C    = 2;
    localparam int FLG_V    = 3;
    localparam int FLG_BUSY = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MPY  = 1'b1
    } mpy_state_e;

endpackage

// File: rtl/alu_mpy_seq.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// state   | meaning
// ST_IDLE | waiting for start, operands latched on start
// ST_MPY  | iterating; done pulses during the last iteration
module alu_mpy_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int MPY_CYCLES = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] prod_hi,
    output logic [DATA_W-1:0] prod_lo
);

    localparam int CNT_W = $clog2(MPY_CYCLES + 1);

    mpy_state_e                state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [2*DATA_W-1:0]       mcand;
    logic [DATA_W-1:0]         mplr;
    logic [2*DATA_W-1:0]       prod;
    logic [2*DATA_W-1:0]       prod_step;

    // Partial product after the current iteration; on the last one it is the result.
    assign prod_step = prod + (mplr[0] ? mcand : '0);
    assign busy      = (state == ST_MPY);
    assign done      = (state == ST_MPY) && (cnt == CNT_W'(1));
    assign prod_hi   = prod_step[2*DATA_W-1:DATA_W];
    assign prod_lo   = prod_step[DATA_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_MPY;
            ST_MPY:  if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mcand <= '0;
            mplr  <= '0;
            prod  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                mcand <= {{DATA_W{1'b0}}, a};
                mplr  <= b;
                prod  <= '0;
                cnt   <= CNT_W'(MPY_CYCLES);
            end else if (state == ST_MPY) begin
                prod  <= prod_step;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_acc_unit.sv
// Accumulator datapath stage: ACC/BR/MR registers, ALU ops and flags.
// Define ALU_FAST_MPY_EN for a single-cycle combinational multiply instead of alu_mpy_seq.
module alu_acc_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int MPY_CYCLES = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       control_signal,
    input  logic [DATA_W-1:0] mbr_in,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] mr_out,
    output logic [7:0]        flags,
    output logic              busy
);

    logic [DATA_W-1:0] acc, br, mr;
    logic              z_f, n_f, c_f, v_f;
    logic [DATA_W-1:0] acc_nxt, mr_nxt;
    logic              z_nxt, n_nxt, c_nxt, v_nxt;
    logic              acc_we, mr_we, br_we, mpy_wr;
    logic [DATA_W:0]   sum, dif;
    logic              unused_cs;

    assign unused_cs = ^{control_signal[20:11], control_signal[9:7], control_signal[5:0]};

    assign sum = {1'b0, acc} + {1'b0, br};
    assign dif = {1'b0, acc} - {1'b0, br};

`ifdef ALU_FAST_MPY_EN
    logic [2*DATA_W-1:0] prod_fast;
    assign prod_fast = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, br};
    assign busy      = 1'b0;
`else
    logic              mpy_start, mpy_done;
    logic [DATA_W-1:0] prod_hi, prod_lo;

    alu_mpy_seq #(
        .DATA_W     (DATA_W),
        .MPY_CYCLES (MPY_CYCLES)
    ) u_mpy (
        .clk     (clk),
        .rst     (rst),
        .start   (mpy_start),
        .a       (acc),
        .b       (br),
        .busy    (busy),
        .done    (mpy_done),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo)
    );
`endif

    assign br_we = control_signal[CS_MBR2BR] && !busy;

    always_comb begin
        acc_nxt = acc;
        mr_nxt  = mr;
        c_nxt   = c_f;
        v_nxt   = v_f;
        acc_we  = 1'b0;
        mr_we   = 1'b0;
        mpy_wr  = 1'b0;
`ifndef ALU_FAST_MPY_EN
        mpy_start = 1'b0;
        if (mpy_done) begin
            acc_we  = 1'b1;
            mr_we   = 1'b1;
            mpy_wr  = 1'b1;
            acc_nxt = prod_lo;
            mr_nxt  = prod_hi;
            c_nxt   = 1'b0;
            v_nxt   = |prod_hi;
        end else
`endif
        if (!busy) begin
            acc_we = 1'b1;
            // Logical and arithmetic-right shifts leave no overflow meaning, so V clears.
            if (control_signal[CS_MPY]) begin
`ifdef ALU_FAST_MPY_EN
                mr_we   = 1'b1;
                mpy_wr  = 1'b1;
                acc_nxt = prod_fast[DATA_W-1:0];
                mr_nxt  = prod_fast[2*DATA_W-1:DATA_W];
                c_nxt   = 1'b0;
                v_nxt   = |prod_fast[2*DATA_W-1:DATA_W];
`else
                acc_we    = 1'b0;
                mpy_start = 1'b1;
`endif
            end else if (control_signal[CS_ADD]) begin
                acc_nxt = sum[DATA_W-1:0];
                c_nxt   = sum[DATA_W];
                v_nxt   = (acc[DATA_W-1] == br[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
            end else if (control_signal[CS_SUB]) begin
                acc_nxt = dif[DATA_W-1:0];
                c_nxt   = !dif[DATA_W];
                v_nxt   = (acc[DATA_W-1] != br[DATA_W-1]) && (dif[DATA_W-1] != acc[DATA_W-1]);
            end else if (control_signal[CS_AND]) begin
                acc_nxt = acc & br;
                c_nxt   = 1'b0;
                v_nxt   = 1'b0;
            end else if (control_signal[CS_OR]) begin
                acc_nxt = acc | br;
                c_nxt   = 1'b0;
                v_nxt   = 1'b0;
            end else if (control_signal[CS_NOT]) begin
                acc_nxt = ~acc;
                c_nxt   = 1'b0;
                v_nxt   = 1'b0;
            end else if (control_signal[CS_LSL]) begin
                acc_nxt = {acc[DATA_W-2:0], 1'b0};
                c_nxt   = acc[DATA_W-1];
                v_nxt   = 1'b0;
            end else if (control_signal[CS_LSR]) begin
                acc_nxt = {1'b0, acc[DATA_W-1:1]};
                c_nxt   = acc[0];
                v_nxt   = 1'b0;
            end else if (control_signal[CS_ASL]) begin
                acc_nxt = {acc[DATA_W-2:0], 1'b0};
                c_nxt   = acc[DATA_W-1];
                v_nxt   = acc[DATA_W-1] ^ acc[DATA_W-2];
            end else if (control_signal[CS_ASR]) begin
                acc_nxt = {acc[DATA_W-1], acc[DATA_W-1:1]};
                c_nxt   = acc[0];
                v_nxt   = 1'b0;
            end else if (control_signal[CS_MBR2ACC]) begin
                acc_nxt = mbr_in;
                c_nxt   = 1'b0;
                v_nxt   = 1'b0;
            end else if (control_signal[CS_ACC_CLEAR]) begin
                acc_nxt = '0;
                c_nxt   = 1'b0;
                v_nxt   = 1'b0;
            end else begin
                acc_we = 1'b0;
            end
        end
        z_nxt = mpy_wr ? ({mr_nxt, acc_nxt} == '0) : (acc_nxt == '0);
        n_nxt = mpy_wr ? mr_nxt[DATA_W-1] : acc_nxt[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            br  <= '0;
            mr  <= '0;
            z_f <= 1'b0;
            n_f <= 1'b0;
            c_f <= 1'b0;
            v_f <= 1'b0;
        end else begin
            if (acc_we) begin
                acc <= acc_nxt;
                z_f <= z_nxt;
                n_f <= n_nxt;
                c_f <= c_nxt;
                v_f <= v_nxt;
            end
            if (mr_we) mr <= mr_nxt;
            if (br_we) br <= mbr_in;
        end
    end

    assign alu_out = acc;
    assign mr_out  = mr;
    assign flags   = {3'b000, busy, v_f, c_f, n_f, z_f};

endmodule

// File: tb/tb_alu_acc_unit.sv
// Directed and randomized checks of alu_acc_unit against an arithmetic reference model.
module tb_alu_acc_unit;
    import cpu_pkg::*;

`ifdef ALU_FAST_MPY_EN
    localparam int EXP_BUSY = 0;
`else
    localparam int EXP_BUSY = 16;
`endif
    localparam logic [31:0] IGN_MASK = 32'h001F_FBBF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] control_signal = '0;
    logic [15:0] mbr_in = '0;
    logic [15:0] alu_out, mr_out;
    logic [7:0]  flags;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_acc = '0, m_br = '0, m_mr = '0, m_a = '0, m_b = '0;
    logic        m_z = 1'b0, m_n = 1'b0, m_c = 1'b0, m_v = 1'b0;
    int          m_left = 0;

    alu_acc_unit #(.DATA_W(16), .MPY_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .mbr_in         (mbr_in),
        .alu_out        (alu_out),
        .mr_out         (mr_out),
        .flags          (flags),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mpy_finish(input logic [31:0] full);
        m_mr  = full[31:16];
        m_acc = full[15:0];
        m_z   = (full == 0);
        m_n   = m_mr[15];
        m_c   = 1'b0;
        m_v   = (m_mr != 0);
    endtask

    task automatic model_update(input logic [31:0] cs, input logic [15:0] mbr, input logic rst_v);
        logic [15:0] r, nb;
        logic        c, v, wr;
        int          sa;
        if (!rst_v) begin
            m_acc = 0; m_br = 0; m_mr = 0; m_left = 0;
            m_z = 0; m_n = 0; m_c = 0; m_v = 0;
            return;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) mpy_finish(32'(m_a) * 32'(m_b));
            return;
        end
        nb = cs[CS_MBR2BR] ? mbr : m_br;
        wr = 1'b1; r = m_acc; c = 1'b0; v = 1'b0;
        if (cs[CS_MPY]) begin
            wr = 1'b0;
`ifdef ALU_FAST_MPY_EN
            mpy_finish(32'(m_acc) * 32'(m_br));
`else
            m_a = m_acc; m_b = m_br; m_left = 16;
`endif
        end else if (cs[CS_ADD]) begin
            r  = m_acc + m_br;
            c  = (int'(m_acc) + int'(m_br)) > 65535;
            sa = int'($signed(m_acc)) + int'($signed(m_br));
            v  = (sa > 32767) || (sa < -32768);
        end else if (cs[CS_SUB]) begin
            r  = m_acc - m_br;
            c  = (m_acc >= m_br);
            sa = int'($signed(m_acc)) - int'($signed(m_br));
            v  = (sa > 32767) || (sa < -32768);
        end else if (cs[CS_AND]) r = m_acc & m_br;
        else if (cs[CS_OR])      r = m_acc | m_br;
        else if (cs[CS_NOT])     r = ~m_acc;
        else if (cs[CS_LSL]) begin r = m_acc << 1; c = m_acc[15]; end
        else if (cs[CS_LSR]) begin r = m_acc >> 1; c = m_acc[0]; end
        else if (cs[CS_ASL]) begin r = m_acc << 1; c = m_acc[15]; v = (r[15] != m_acc[15]); end
        else if (cs[CS_ASR]) begin r = $signed(m_acc) >>> 1; c = m_acc[0]; end
        else if (cs[CS_MBR2ACC])   r = mbr;
        else if (cs[CS_ACC_CLEAR]) r = 0;
        else wr = 1'b0;
        if (wr) begin
            m_acc = r; m_z = (r == 0); m_n = r[15]; m_c = c; m_v = v;
        end
        m_br = nb;
    endtask

    task automatic step(input logic [31:0] cs, input logic [15:0] mbr, input logic rst_v);
        control_signal = cs;
        mbr_in         = mbr;
        rst            = rst_v;
        model_update(cs, mbr, rst_v);
        @(posedge clk);
        #1;
        check("alu_out", alu_out, m_acc);
        check("mr_out", mr_out, m_mr);
        check("flags", flags, {3'b000, (m_left > 0), m_v, m_c, m_n, m_z});
        check("busy", busy, (m_left > 0));
    endtask

    function automatic logic [31:0] bit_of(input int idx);
        return 32'(1) << idx;
    endfunction

    initial begin
        int          ops[13] = '{6, 10, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31};
        int          nbusy;
        logic [31:0] cs;
        logic [15:0] mbr;
        int          k;

        // Reset with random control activity
        step($urandom, 16'($urandom), 1'b0);
        step($urandom, 16'($urandom), 1'b0);
        check("rst_acc", alu_out, 0);
        check("rst_flags", flags, 8'h00);
        check("rst_busy", busy, 0);

        // LOAD-style: BR <= MBR with ACC cleared, then ACC+BR
        step(bit_of(CS_MBR2BR) | bit_of(CS_ACC_CLEAR), 16'h1234, 1'b1);
        step(bit_of(CS_ADD), 16'h0000, 1'b1);
        check("load_acc", alu_out, 16'h1234);
        check("load_flags", flags, 8'h00);

        // Signed overflow on add
        step(bit_of(CS_MBR2ACC), 16'h7FFF, 1'b1);
        step(bit_of(CS_MBR2BR), 16'h0001, 1'b1);
        step(bit_of(CS_ADD), 16'h0000, 1'b1);
        check("addov_acc", alu_out, 16'h8000);
        check("addov_flags", flags, 8'h0A);

        // Subtract to zero
        step(bit_of(CS_MBR2ACC) | bit_of(CS_MBR2BR), 16'h00FF, 1'b1);
        step(bit_of(CS_SUB), 16'h0000, 1'b1);
        check("subz_acc", alu_out, 16'h0000);
        check("subz_flags", flags, 8'h05);

        // Multiply with an add pulsed while busy
        step(bit_of(CS_MBR2ACC), 16'h0300, 1'b1);
        step(bit_of(CS_MBR2BR), 16'h0100, 1'b1);
        step(bit_of(CS_MPY), 16'h0000, 1'b1);
        nbusy = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            nbusy++;
            step((i == 3) ? bit_of(CS_ADD) : 32'h0, 16'h0000, 1'b1);
        end
        check("mpy_busy_cycles", nbusy, EXP_BUSY);
        check("mpy_mr", mr_out, 16'h0003);
        check("mpy_acc", alu_out, 16'h0000);
        check("mpy_flags", flags, 8'h08);

        // Arithmetic shift right, then reset during a multiply
        step(bit_of(CS_MBR2ACC), 16'h8001, 1'b1);
        step(bit_of(CS_ASR), 16'h0000, 1'b1);
        check("asr_acc", alu_out, 16'hC000);
        check("asr_flags", flags, 8'h06);
        step(bit_of(CS_MPY), 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) step(32'h0, 16'h0000, 1'b1);
        step(32'h0, 16'h0000, 1'b0);
        check("rstmpy_acc", alu_out, 16'h0000);
        check("rstmpy_mr", mr_out, 16'h0000);
        check("rstmpy_flags", flags, 8'h00);
        check("rstmpy_busy", busy, 0);
        step(32'h0, 16'h0000, 1'b1);

        // Randomized micro-op streams
        for (int n = 0; n < 1500; n++) begin
            cs = $urandom & IGN_MASK;
            for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
                k = int'($urandom_range(0, 12));
                if (ops[k] == CS_MPY && $urandom_range(0, 2) != 0) k = 2;
                cs |= bit_of(ops[k]);
            end
            case ($urandom_range(0, 7))
                0:       mbr = 16'h0000;
                1:       mbr = 16'h8000;
                2:       mbr = 16'h7FFF;
                3:       mbr = 16'hFFFF;
                default: mbr = 16'($urandom);
            endcase
            step(cs, mbr, ($urandom_range(0, 99) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_acc_unit.md
Name: alu_acc_unit

Overview:
- Datapath execution stage directly downstream of the microprogrammed control unit.
- Consumes the registered 32-bit control word, one micro-op per cycle.
- Owns the ACC, BR and MR registers and performs arithmetic, logic and shift operations.
- Returns an 8-bit flags vector to the control unit; JMPGEZ decisions use its N flag.

Parameters:
- DATA_W, 16, width of ACC/BR/MR/MBR data path.
- MPY_CYCLES, DATA_W, iterations of the sequential multiplier (must equal DATA_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- control_signal  in  32  one-hot-ish micro-op word from the control unit.
- mbr_in  in  DATA_W  current MBR value.
- alu_out  out  DATA_W  ACC value, driven to MBR when control bit 11 or 16 is set.
- mr_out  out  DATA_W  MR value, driven to MBR when control bit 15 is set.
- flags  out  8  [0]=Z, [1]=N, [2]=C, [3]=V, [4]=BUSY, [7:5]=0.
- busy  out  1  multiplier in progress; equals flags[4].

Behaviour:
- Reset (rst=0 at a clk edge): ACC, BR, MR, flags, busy, alu_out, mr_out and the multiplier counter all go to 0. Reset mid-multiply aborts the multiply with no partial result kept.
- Control bits used: 6 mbr2br, 7 acc2alu, 10 mbr2acc, 14 br2alu, 21 acc_clear, 22 add, 23 sub, 24 and, 25 or, 26 not, 27 lsl, 28 lsr, 29 mpy, 30 asl, 31 asr. All other bits are ignored.
- mbr2br: BR <= mbr_in at the edge. It may coincide with any ACC op; the op uses the old BR.
- ACC writer priority, at most one applied per cycle: mpy > add > sub > and > or > not > lsl > lsr > asl > asr > mbr2acc > acc_clear.
- add: ACC <= ACC+BR. C = carry out; V = signed overflow.
- sub: ACC <= ACC-BR. C = borrow-free (1 when ACC >= BR unsigned); V = signed overflow.
- and / or: ACC <= ACC&BR or ACC|BR. not: ACC <= ~ACC. C and V cleared for all three.
- lsl / lsr: shift ACC by 1, zero fill. C = bit shifted out.
- asl: shift left by 1, zero fill. C = bit shifted out; V = 1 if the sign bit changed.
- asr: shift right by 1, sign fill. C = bit shifted out.
- Z and N update from the new ACC on every ACC write, including mbr2acc and acc_clear. C and V are cleared by mbr2acc and acc_clear.
- Single-cycle ops: result is visible in alu_out the cycle after control_signal presents the op.
- mpy (unsigned ACC x BR, 2*DATA_W product):
  - Cycle T op seen: busy=1 from T+1, counter loaded with MPY_CYCLES. Shift-add runs one bit per cycle.
  - At the end of the final iteration, MR = product high half and ACC = low half, on the same edge that busy falls.
  - busy is high for exactly MPY_CYCLES cycles.
  - Final flags: Z = (full product == 0), N = MR[msb], C = 0, V = (MR != 0).
- While busy: every control bit that writes ACC, BR or MR is ignored, including a second mpy.
- FSM states: IDLE, MPY.
  - IDLE -> MPY on mpy bit.
  - MPY -> IDLE when the counter reaches 0.
  - Any state -> IDLE on reset.
- alu_out = ACC and mr_out = MR continuously. They are register outputs, with no combinational path from control_signal.

Optional Feature:
- ALU_FAST_MPY_EN defined: mpy completes in one cycle using a combinational multiplier. MR:ACC and flags update at T+1. busy and flags[4] are tied to 0, and the MPY state is not built.
- Not defined: sequential shift-add multiplier as specified above.

Decomposition:
- cpu_pkg holds:
  - Control-bit index constants (CS_MBR2BR=6 ... CS_ASR=31).
  - Opcode constants shared with the control unit.
  - Flag index constants (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3, FLG_BUSY=4).
  - The DATA_W default.
- One sub-module: alu_mpy_seq. It contains the shift-add multiplier with its counter and start/busy/done handshake, and is instantiated only when ALU_FAST_MPY_EN is undefined.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random control_signal -> ACC=BR=MR=0, flags=8'h00, busy=0.
- LOAD-style sequence: mbr_in=16'h1234, cycle 1 bits 6|21, cycle 2 bit 22 -> ACC=16'h1234, Z=0, N=0.
- Add overflow: ACC=16'h7FFF, BR=16'h0001, add -> ACC=16'h8000, N=1, V=1, C=0.
- Sub to zero: ACC=BR=16'h00FF, sub -> ACC=0, Z=1, C=1.
- Multiply: ACC=16'h0300, BR=16'h0100, mpy -> busy high exactly 16 cycles, then MR=16'h0003, ACC=16'h0000, V=1, Z=0.
  - Also pulse add mid-multiply -> ignored.
- Shift and reset mid-multiply:
  - ACC=16'h8001, asr -> ACC=16'hC000, C=1.
  - Then start mpy and assert rst at iteration 5 -> all registers 0, busy=0 next cycle.
